// File: rtl/eq_pkg.sv
// Shared widths, FSM state encoding and gain-vector helper for the equalizer band scheduler.
package eq_pkg;

   localparam int NUM_BANDS = 8;
   localparam int SAMPLE_W  = 16;
   localparam int GAIN_W    = 5;
   localparam int BAND_W    = 3;
   localparam int GAINS_W   = NUM_BANDS * GAIN_W;
   localparam int PROD_W    = SAMPLE_W + GAIN_W + 1;
   localparam int ACC_W     = PROD_W + 3;

   localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACC,
      DONE
   } state_t;

   function automatic logic [GAIN_W-1:0] gainSlice(input logic [GAINS_W-1:0] gains,
                                                   input logic [BAND_W-1:0]  band);
      return gains[int'(band) * GAIN_W +: GAIN_W];
   endfunction

endpackage

// File: rtl/eq_saturate.sv
// Arithmetic right shift followed by a clamp from a wide signed value to a narrower signed range.
module eq_saturate #(
   parameter int IN_W  = 25,
   parameter int OUT_W = 16,
   parameter int SHIFT = 0
) (
   input  logic signed [IN_W-1:0]  i_value,
   output logic signed [OUT_W-1:0] o_value
);

   localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [IN_W-1:0] w_shifted;

   always_comb begin
      w_shifted = i_value >>> SHIFT;
      if (w_shifted > MAX_V) begin
         o_value = MAX_V[OUT_W-1:0];
      end else if (w_shifted < MIN_V) begin
         o_value = MIN_V[OUT_W-1:0];
      end else begin
         o_value = w_shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/eq_band_scheduler.sv
// Time-shares one external FIR engine across all equalizer bands per input sample,
// weighting each band result by its gain and emitting one saturated output per frame.
module eq_band_scheduler
   import eq_pkg::*;
#(
   parameter int GAIN_SHIFT = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sample_valid,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic [GAINS_W-1:0]         gain,
   output logic                       fir_start,
   output logic [BAND_W-1:0]          fir_band,
   output logic signed [SAMPLE_W-1:0] fir_sample,
   input  logic                       fir_done,
   input  logic signed [SAMPLE_W-1:0] fir_result,
   output logic signed [SAMPLE_W-1:0] out_sample,
   output logic                       out_valid,
   output logic                       busy,
   output logic                       overrun
);

   state_t                     r_state;
   state_t                     w_nextState;
   logic [BAND_W-1:0]          r_band;
   logic signed [SAMPLE_W-1:0] r_sample;
   logic signed [SAMPLE_W-1:0] r_outSample;
   logic [GAINS_W-1:0]         r_gainSnap;
   logic signed [PROD_W-1:0]   r_prod;
   logic signed [ACC_W-1:0]    r_acc;
   logic                       r_overrun;

   logic signed [PROD_W-1:0]   w_resExt;
   logic signed [PROD_W-1:0]   w_gainExt;
   logic signed [PROD_W-1:0]   w_prod;
   logic signed [ACC_W-1:0]    w_accSum;
   logic signed [SAMPLE_W-1:0] w_satOut;

   // Gain is unsigned, so it is zero-extended before the signed multiply.
   assign w_resExt  = {{(PROD_W-SAMPLE_W){fir_result[SAMPLE_W-1]}}, fir_result};
   assign w_gainExt = {{(PROD_W-GAIN_W){1'b0}}, gainSlice(r_gainSnap, r_band)};
   assign w_prod    = w_resExt * w_gainExt;
   assign w_accSum  = r_acc + {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};

   eq_saturate #(
      .IN_W  (ACC_W),
      .OUT_W (SAMPLE_W),
      .SHIFT (GAIN_SHIFT)
   ) u_saturate (
      .i_value (w_accSum),
      .o_value (w_satOut)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (sample_valid) w_nextState = ISSUE;
         ISSUE:   w_nextState = WAIT;
         WAIT:    if (fir_done) w_nextState = ACC;
         ACC:     w_nextState = (r_band == LAST_BAND) ? DONE : ISSUE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // The output sample is taken from the final accumulate sum so it is ready in the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_band      <= '0;
         r_sample    <= '0;
         r_outSample <= '0;
         r_gainSnap  <= '0;
         r_prod      <= '0;
         r_acc       <= '0;
         r_overrun   <= 1'b0;
      end else begin
         if (sample_valid && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (sample_valid) begin
                  r_sample   <= sample_in;
                  r_gainSnap <= gain;
                  r_acc      <= '0;
                  r_band     <= '0;
               end
            end
            WAIT: begin
               if (fir_done) begin
                  r_prod <= w_prod;
               end
            end
            ACC: begin
               r_acc <= w_accSum;
               if (r_band == LAST_BAND) begin
                  r_outSample <= w_satOut;
               end else begin
                  r_band <= r_band + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign fir_start  = (r_state == ISSUE);
   assign fir_band   = r_band;
   assign fir_sample = r_sample;
   assign out_sample = r_outSample;
   assign out_valid  = (r_state == DONE);
   assign busy       = (r_state != IDLE);
   assign overrun    = r_overrun;

endmodule

// File: doc/eq_band_scheduler.md
# eq_band_scheduler

Per-sample sequencer that time-shares one FIR band engine across all eight equalizer bands. On each accepted input sample it issues eight band jobs in order, weights each band result by that band's 5-bit gain, and accumulates. It then emits one saturated output sample. It sits between the sample-rate front end and the shared FIR engine, on the fast FIR clock.

## Interface
- `SAMPLE_W`, 16, width of input, FIR result and output samples (signed)
- `GAIN_W`, 5, per-band gain width (unsigned)
- `NUM_BANDS`, 8, number of bands sequenced
- `GAIN_SHIFT`, 0, arithmetic right shift applied to the accumulator before saturation (0 means gain 1 is unity)

- `clk` in 1: single clock; all logic on the rising edge
- `rst` in 1: synchronous, active-high reset
- `sample_valid` in 1: one-cycle strobe; `sample_in` is valid
- `sample_in` in SAMPLE_W: signed input sample
- `gain` in NUM_BANDS*GAIN_W: band b gain at bits [b*GAIN_W +: GAIN_W]
- `fir_start` out 1: one-cycle job-start pulse to the FIR engine
- `fir_band` out 3: band index of the current job
- `fir_sample` out SAMPLE_W: latched sample for the current frame
- `fir_done` in 1: one-cycle pulse; `fir_result` is valid
- `fir_result` in SAMPLE_W: signed band output
- `out_sample` out SAMPLE_W: signed equalized sample
- `out_valid` out 1: one-cycle strobe; `out_sample` is updated
- `busy` out 1: high whenever the state is not IDLE
- `overrun` out 1: sticky flag; a sample was dropped

## Operation
- **IDLE**
  - On `sample_valid`: latch `sample_in` into `fir_sample`, snapshot `gain` for the whole frame, clear acc, set band=0.
  - Go to ISSUE.
- **ISSUE**
  - Assert `fir_start` for exactly one cycle, with `fir_band` = band.
  - Go to WAIT.
- **WAIT**
  - Hold until `fir_done`.
  - On `fir_done`, register product = `fir_result` × zero-extended snapshot gain[band] (signed, SAMPLE_W+GAIN_W+1 = 22 bits).
  - Go to ACC.
- **ACC**
  - acc += product. acc is signed SAMPLE_W+GAIN_W+1+3 = 25 bits and cannot overflow.
  - If band == NUM_BANDS-1, go to DONE. Otherwise band++ and go to ISSUE.
- **DONE**
  - `out_sample` = sat(acc >>> GAIN_SHIFT) to [-32768, 32767].
  - Pulse `out_valid`.
  - Go to IDLE.
- All bands run every frame, including zero-gain bands, so every FIR delay line advances on every sample.
- `fir_done` outside WAIT is ignored.
- `sample_valid` outside IDLE: the sample is dropped, the current frame is unaffected, and `overrun` is set. `overrun` is cleared only by `rst`.
- `gain` changes during a frame take effect from the next frame.
- Reset values: state IDLE, `fir_start` 0, `fir_band` 0, `fir_sample` 0, `out_sample` 0, `out_valid` 0, `busy` 0, `overrun` 0, acc 0.
- `rst` mid-frame aborts the frame:
  - no `out_valid` for it;
  - `fir_start` is low from the cycle after `rst`;
  - a late `fir_done` is ignored.

## Timing
- `sample_valid` sampled in cycle t. Engine `fir_done` arrives D ≥ 1 cycles after `fir_start`.
- Band k `fir_start` is in cycle t+1+k(D+2).
- `out_valid` (DONE) is in cycle t+8(D+2)+1. For D=1 that is t+25.
- IDLE is re-entered at t+8(D+2)+2. The earliest next accepted `sample_valid` is in that cycle.
- The sample period must be ≥ 8(D+2)+2 clk cycles; otherwise `overrun` is set.
- `busy` rises in cycle t+1 and falls in cycle t+8(D+2)+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `eq_pkg`:
  - constants NUM_BANDS, SAMPLE_W, GAIN_W, PROD_W, ACC_W;
  - state enum {IDLE, ISSUE, WAIT, ACC, DONE};
  - gain-slice helper.
- One sub-module, `eq_saturate`: parameterized shift + clamp from ACC_W to SAMPLE_W, shared with the other gain paths.
- The FIR engine is external. The bench uses a behavioural model with programmable D, returning `fir_result` = `fir_sample`.

## Test plan
1. **Reset and unity sum.**
   - Hold `rst` 3 cycles: all outputs 0.
   - Gains b0=1, b1=1, others 0; `sample_in`=1000 at t; D=1.
   - Expect `out_valid` at t+25 with `out_sample`=2000, and exactly 8 `fir_start` pulses with bands 0..7.
2. **Saturation.**
   - All gains 31, `sample_in`=30000 → 32767.
   - `sample_in`=-30000 → -32768.
   - All gains 0, `sample_in`=12345 → 0.
3. **Overrun.**
   - Second `sample_valid` (value 500) at t+10.
   - Expect `overrun`=1 from t+11, output 2000 for the first sample only, and no second frame.
4. **Gain snapshot.**
   - Change b0 gain 1→4 at t+5.
   - Current frame outputs 2000; next frame with 1000 outputs 5000.
5. **Reset mid-frame.**
   - `rst` at t+8; bench issues `fir_done` at t+9.
   - `busy`=0 and `fir_start`=0 from t+9, no `out_valid`, state IDLE; the next sample processes normally.
6. **Latency scaling.**
   - D=4: `out_valid` at t+49.
   - Back-to-back samples every 50 cycles: no overrun.
   - Every 49 cycles: `overrun`=1.
